// File: rtl/product_piso.sv
// product_piso: parallel-in / serial-out transmitter for one product word.
// A load in IDLE captures P; bits leave MSB first while shift_enable is high,
// then a one-cycle DONE state pulses piso_done before returning to IDLE.
// Optional feature macro: PISO_PARITY_EN appends one even-parity bit
// (XOR of the captured word) after the last data bit.
module product_piso #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] P,
  input  logic             load,
  input  logic             shift_enable,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             piso_done
);

`ifdef PISO_PARITY_EN
  // Data bits followed by the parity bit, all carried in one shift register.
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif

  // Sized so the counter can reach NBITS without wrapping.
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST_IDX = CW'(NBITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [NBITS-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NBITS-1:0] load_word;

  // Word captured on an accepted load; parity sits below the LSB so it goes out last.
`ifdef PISO_PARITY_EN
  assign load_word = {P, ^P};
`else
  assign load_word = P;
`endif

  // State, shift register and bit counter; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: loads only count in IDLE; shifting only advances on shift_enable.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          shreg_d = load_word;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_enable) begin
          shreg_d = {shreg_q[NBITS-2:0], 1'b0};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode from registered state only, so a stall naturally holds them.
  always_comb begin
    serial_out = 1'b0;
    bit_valid  = 1'b0;
    busy       = 1'b0;
    piso_done  = 1'b0;
    case (state_q)
      SHIFT: begin
        serial_out = shreg_q[NBITS-1];
        bit_valid  = 1'b1;
        busy       = 1'b1;
      end
      DONE: begin
        piso_done = 1'b1;
      end
      default: begin
        serial_out = 1'b0;
      end
    endcase
  end

endmodule
